// File: rtl/conv_raddr_pkg.sv
// Shared types and helpers for the convolution read-address generator.
// The controller FSM state type and the circular-distance function live here.
package conv_raddr_pkg;

  localparam int DIST_W = 16;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    FILT_INIT = 3'd1,
    WIN_INIT  = 3'd2,
    READ      = 3'd3,
    WAIT_PSUM = 3'd4
  } state_e;

  // Distance of a ring pointer ahead of base; both operands must be below depth.
  function automatic logic [DIST_W-1:0] circ_dist(input logic [DIST_W-1:0] a,
                                                   input logic [DIST_W-1:0] base,
                                                   input logic [DIST_W-1:0] depth);
    return (a + depth - base) % depth;
  endfunction

endpackage

// File: rtl/conv_circ_dist.sv
// Circular distance of one IF scratchpad pointer from the window base pointer.
module conv_circ_dist
  import conv_raddr_pkg::*;
#(
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 24
) (
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [ADDR_W-1:0] base_i,
  output logic [ADDR_W-1:0] dist_o
);

  assign dist_o = ADDR_W'(circ_dist(DIST_W'(addr_i), DIST_W'(base_i), DIST_W'(DEPTH)));

endmodule

// File: rtl/conv_raddr_gen.sv
// Read-address generator walking filters x windows x taps over a circular IF scratchpad.
// Define CONV_RADDR_DILATION_EN to add the cfg_dilation port (0 behaves as 1).
module conv_raddr_gen
  import conv_raddr_pkg::*;
#(
  parameter int IF_ADDR_LEN   = 5,
  parameter int FILT_ADDR_LEN = 6,
  parameter int IF_DEPTH      = 24,
  parameter int NUM_FILT_MAX  = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic                         psum_done,
  input  logic [IF_ADDR_LEN-1:0]       cfg_stride,
  input  logic [FILT_ADDR_LEN-1:0]     cfg_filt_len,
  input  logic [$clog2(NUM_FILT_MAX):0] cfg_num_filt,
`ifdef CONV_RADDR_DILATION_EN
  input  logic [IF_ADDR_LEN-1:0]       cfg_dilation,
`endif
  input  logic [IF_ADDR_LEN-1:0]       if_start_pos,
  input  logic [IF_ADDR_LEN-1:0]       if_end_pos,
  input  logic [IF_ADDR_LEN-1:0]       if_waddr,
  input  logic                         if_end_valid,
  input  logic [FILT_ADDR_LEN-1:0]     filt_waddr,
  input  logic                         filt_ready,
  input  logic                         rd_ready,
  output logic                         rd_valid,
  output logic [IF_ADDR_LEN-1:0]       if_raddr,
  output logic [FILT_ADDR_LEN-1:0]     filt_raddr,
  output logic                         tap_last,
  output logic                         win_done,
  output logic                         full_done,
  output logic                         busy
);

  localparam int NF_W = $clog2(NUM_FILT_MAX) + 1;
  localparam int WIDE = 2 * IF_ADDR_LEN + FILT_ADDR_LEN;

  state_e                     state_q, state_d;
  logic [NF_W-1:0]            filt_idx_q, filt_idx_d;
  logic [IF_ADDR_LEN-1:0]     win_idx_q, win_idx_d;
  logic [FILT_ADDR_LEN-1:0]   tap_q, tap_d;
  logic                       win_done_q, win_done_d;
  logic                       full_done_q, full_done_d;

  logic [FILT_ADDR_LEN-1:0]   last_tap;
  logic [WIDE-1:0]            win_base_w, tap_off_w, last_off_w;
  logic [IF_ADDR_LEN-1:0]     last_addr;
  logic [IF_ADDR_LEN-1:0]     rd_dist, wr_dist, last_dist, end_dist;
  logic                       read_safe, win_ovf;

  assign last_tap = cfg_filt_len - FILT_ADDR_LEN'(1);

`ifdef CONV_RADDR_DILATION_EN
  logic [WIDE-1:0] dil_w;
  assign dil_w      = (cfg_dilation == '0) ? WIDE'(1) : WIDE'(cfg_dilation);
  assign tap_off_w  = WIDE'(tap_q) * dil_w;
  assign last_off_w = WIDE'(last_tap) * dil_w;
`else
  assign tap_off_w  = WIDE'(tap_q);
  assign last_off_w = WIDE'(last_tap);
`endif

  // Sums are kept wide so the modulo sees the untruncated ring offset.
  assign win_base_w = WIDE'(if_start_pos) + WIDE'(win_idx_q) * WIDE'(cfg_stride);
  assign if_raddr   = IF_ADDR_LEN'((win_base_w + tap_off_w) % WIDE'(IF_DEPTH));
  assign last_addr  = IF_ADDR_LEN'((win_base_w + last_off_w) % WIDE'(IF_DEPTH));
  assign filt_raddr = FILT_ADDR_LEN'(filt_idx_q) * cfg_filt_len + tap_q;

  conv_circ_dist #(.ADDR_W(IF_ADDR_LEN), .DEPTH(IF_DEPTH)) u_dist_rd (
    .addr_i(if_raddr), .base_i(if_start_pos), .dist_o(rd_dist));
  conv_circ_dist #(.ADDR_W(IF_ADDR_LEN), .DEPTH(IF_DEPTH)) u_dist_wr (
    .addr_i(if_waddr), .base_i(if_start_pos), .dist_o(wr_dist));
  conv_circ_dist #(.ADDR_W(IF_ADDR_LEN), .DEPTH(IF_DEPTH)) u_dist_last (
    .addr_i(last_addr), .base_i(if_start_pos), .dist_o(last_dist));
  conv_circ_dist #(.ADDR_W(IF_ADDR_LEN), .DEPTH(IF_DEPTH)) u_dist_end (
    .addr_i(if_end_pos), .base_i(if_start_pos), .dist_o(end_dist));

  assign read_safe = (rd_dist < wr_dist) && ((filt_raddr < filt_waddr) || filt_ready);
  assign win_ovf   = last_dist > end_dist;

  assign rd_valid  = (state_q == READ) && read_safe;
  assign tap_last  = (tap_q == last_tap);
  assign busy      = (state_q != IDLE);
  assign win_done  = win_done_q;
  assign full_done = full_done_q;

  // An overflowing window only retires the filter once the end pointer is final.
  always_comb begin
    state_d     = state_q;
    filt_idx_d  = filt_idx_q;
    win_idx_d   = win_idx_q;
    tap_d       = tap_q;
    win_done_d  = 1'b0;
    full_done_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          filt_idx_d = '0;
          state_d    = FILT_INIT;
        end
      end
      FILT_INIT: begin
        if (filt_idx_q == cfg_num_filt) begin
          full_done_d = 1'b1;
          state_d     = IDLE;
        end else begin
          win_idx_d = '0;
          state_d   = WIN_INIT;
        end
      end
      WIN_INIT: begin
        if (win_ovf) begin
          if (if_end_valid) begin
            filt_idx_d = filt_idx_q + NF_W'(1);
            state_d    = FILT_INIT;
          end
        end else begin
          tap_d   = '0;
          state_d = READ;
        end
      end
      READ: begin
        if (rd_valid && rd_ready) begin
          if (tap_last) state_d = WAIT_PSUM;
          else          tap_d   = tap_q + FILT_ADDR_LEN'(1);
        end
      end
      WAIT_PSUM: begin
        if (psum_done) begin
          win_done_d = 1'b1;
          win_idx_d  = win_idx_q + IF_ADDR_LEN'(1);
          state_d    = WIN_INIT;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      filt_idx_q  <= '0;
      win_idx_q   <= '0;
      tap_q       <= '0;
      win_done_q  <= 1'b0;
      full_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      filt_idx_q  <= filt_idx_d;
      win_idx_q   <= win_idx_d;
      tap_q       <= tap_d;
      win_done_q  <= win_done_d;
      full_done_q <= full_done_d;
    end
  end

endmodule

// File: tb/tb_conv_raddr_gen.sv
// Scoreboard bench for conv_raddr_gen: a pass-level reference model fills an event
// queue, a negedge monitor pops and compares every read handshake and done pulse.
module tb_conv_raddr_gen;

  localparam int DEPTH      = 24;
  localparam int KIND_READ  = 0;
  localparam int KIND_WIN   = 1;
  localparam int KIND_FULL  = 2;
  localparam int BUDGET     = 4000;

  logic       clk = 1'b0;
  logic       rst, start, psum_done;
  logic [4:0] cfg_stride;
  logic [5:0] cfg_filt_len;
  logic [2:0] cfg_num_filt;
  logic [4:0] cfg_dilation;
  logic [4:0] if_start_pos, if_end_pos, if_waddr;
  logic       if_end_valid;
  logic [5:0] filt_waddr;
  logic       filt_ready, rd_ready;
  logic       rd_valid, tap_last, win_done, full_done, busy;
  logic [4:0] if_raddr;
  logic [5:0] filt_raddr;

  typedef struct {
    int kind;
    int ifA;
    int fA;
    int last;
  } exp_t;

  exp_t expQ[$];
  int   vecCount = 0;
  int   missCount = 0;
  bit   readyRandom = 1'b0;
  bit   holdPending = 1'b0;
  int   heldIf, heldFilt, heldLast;

  conv_raddr_gen dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .psum_done    (psum_done),
    .cfg_stride   (cfg_stride),
    .cfg_filt_len (cfg_filt_len),
    .cfg_num_filt (cfg_num_filt),
`ifdef CONV_RADDR_DILATION_EN
    .cfg_dilation (cfg_dilation),
`endif
    .if_start_pos (if_start_pos),
    .if_end_pos   (if_end_pos),
    .if_waddr     (if_waddr),
    .if_end_valid (if_end_valid),
    .filt_waddr   (filt_waddr),
    .filt_ready   (filt_ready),
    .rd_ready     (rd_ready),
    .rd_valid     (rd_valid),
    .if_raddr     (if_raddr),
    .filt_raddr   (filt_raddr),
    .tap_last     (tap_last),
    .win_done     (win_done),
    .full_done    (full_done),
    .busy         (busy)
  );

  initial forever #5 clk = ~clk;

  task automatic checkOutput(input string name, input int actual, input int expected);
    vecCount++;
    if (actual != expected) begin
      missCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  function automatic int circDist(input int a, input int s);
    return (a - s + DEPTH) % DEPTH;
  endfunction

  // Reference model: every window whose last tap stays within the end pointer is read
  // tap by tap for each filter, followed by a window pulse; a pass pulse closes it.
  task automatic buildExpected(input int startPos, input int stride, input int len,
                               input int nf, input int endPos, input int dil);
    int   d;
    int   base;
    exp_t e;
    d = (dil == 0) ? 1 : dil;
    for (int f = 0; f < nf; f++) begin
      for (int w = 0; w < 64; w++) begin
        base = startPos + w * stride;
        if (circDist((base + (len - 1) * d) % DEPTH, startPos) > circDist(endPos, startPos))
          break;
        for (int t = 0; t < len; t++) begin
          e.kind = KIND_READ;
          e.ifA  = (base + t * d) % DEPTH;
          e.fA   = (f * len + t) % 64;
          e.last = (t == len - 1) ? 1 : 0;
          expQ.push_back(e);
        end
        e.kind = KIND_WIN; e.ifA = 0; e.fA = 0; e.last = 0;
        expQ.push_back(e);
      end
    end
    e.kind = KIND_FULL; e.ifA = 0; e.fA = 0; e.last = 0;
    expQ.push_back(e);
  endtask

  task automatic popCheck(input int kind);
    exp_t e;
    checkOutput("eventExpected", (expQ.size() > 0) ? 1 : 0, 1);
    if (expQ.size() > 0) begin
      e = expQ.pop_front();
      checkOutput("eventKind", kind, e.kind);
      if (kind == KIND_READ && e.kind == KIND_READ) begin
        checkOutput("ifRaddr", int'(if_raddr), e.ifA);
        checkOutput("filtRaddr", int'(filt_raddr), e.fA);
        checkOutput("tapLast", int'(tap_last), e.last);
      end
    end
  endtask

  // Monitor: samples on the falling edge, away from the DUT's active edge.
  always @(negedge clk) begin
    if (rst) begin
      holdPending = 1'b0;
    end else begin
      if (holdPending && rd_valid) begin
        checkOutput("holdIfAddr", int'(if_raddr), heldIf);
        checkOutput("holdFiltAddr", int'(filt_raddr), heldFilt);
        checkOutput("holdTapLast", int'(tap_last), heldLast);
      end
      holdPending = rd_valid && !rd_ready;
      heldIf      = int'(if_raddr);
      heldFilt    = int'(filt_raddr);
      heldLast    = int'(tap_last);
      if (rd_valid && rd_ready) begin
        checkOutput("readSafeIf",
                    (circDist(int'(if_raddr), int'(if_start_pos)) <
                     circDist(int'(if_waddr), int'(if_start_pos))) ? 1 : 0, 1);
        checkOutput("readSafeFilt", ((filt_raddr < filt_waddr) || filt_ready) ? 1 : 0, 1);
        popCheck(KIND_READ);
      end
      if (win_done)  popCheck(KIND_WIN);
      if (full_done) popCheck(KIND_FULL);
    end
  end

  // Consumer side: backpressure and partial-sum retirement, stray psum_done included.
  initial begin
    rd_ready  = 1'b1;
    psum_done = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      rd_ready  = readyRandom ? ($urandom_range(0, 2) != 0) : 1'b1;
      psum_done = ($urandom_range(0, 2) == 0);
    end
  end

  task automatic doReset();
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    expQ.delete();
  endtask

  task automatic applyStimulus(input int startPos, input int stride, input int len,
                               input int nf, input int endPos, input int waddr,
                               input int dil, input bit fReady, input int fWaddr,
                               input bit endValid);
    @(posedge clk); #1;
    expQ.delete();
    cfg_stride   = 5'(stride);
    cfg_filt_len = 6'(len);
    cfg_num_filt = 3'(nf);
    cfg_dilation = 5'(dil);
    if_start_pos = 5'(startPos);
    if_end_pos   = 5'(endPos);
    if_waddr     = 5'(waddr);
    if_end_valid = endValid;
    filt_ready   = fReady;
    filt_waddr   = 6'(fWaddr);
`ifdef CONV_RADDR_DILATION_EN
    buildExpected(startPos, stride, len, nf, endPos, dil);
`else
    buildExpected(startPos, stride, len, nf, endPos, 1);
`endif
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic waitQueue(input int leftover, input bit throttle, input int limit,
                           input bit spam, output bit done);
    done = 1'b0;
    for (int cyc = 0; cyc < BUDGET; cyc++) begin
      @(posedge clk); #1;
      if (expQ.size() <= leftover) begin
        done  = 1'b1;
        start = 1'b0;
        break;
      end
      if (throttle && (cyc % 5 == 4) && (int'(if_waddr) != limit))
        if_waddr = 5'((int'(if_waddr) + 1) % DEPTH);
      start = spam && busy && ($urandom_range(0, 7) == 0);
    end
    start = 1'b0;
  endtask

  task automatic finishPass(input string name, input bit throttle, input int limit,
                            input bit spam);
    bit done;
    waitQueue(0, throttle, limit, spam, done);
    checkOutput({name, "Completed"}, int'(done), 1);
    checkOutput({name, "IdleAfter"}, int'(busy), 0);
    if (!done) doReset();
  endtask

  initial begin
    bit done;
    int stride, len, nf, sp, e, dil, lo;
    rst = 1'b1; start = 1'b0;
    cfg_stride = 5'd1; cfg_filt_len = 6'd1; cfg_num_filt = 3'd1; cfg_dilation = 5'd1;
    if_start_pos = '0; if_end_pos = '0; if_waddr = '0; if_end_valid = 1'b0;
    filt_waddr = '0; filt_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    checkOutput("resetBusy", int'(busy), 0);
    checkOutput("resetRdValid", int'(rd_valid), 0);
    checkOutput("resetWinDone", int'(win_done), 0);
    checkOutput("resetFullDone", int'(full_done), 0);

    $display("[TB] basic pass: start 0, len 3, stride 1, end 9");
    readyRandom = 1'b0;
    applyStimulus(0, 1, 3, 1, 9, 10, 1, 1'b1, 0, 1'b1);
    finishPass("basic", 1'b0, 0, 1'b0);

    $display("[TB] wrap pass: start 20, len 3, stride 2");
    applyStimulus(20, 2, 3, 1, 9, 10, 1, 1'b1, 0, 1'b1);
    finishPass("wrap", 1'b0, 0, 1'b0);

    $display("[TB] two filters, len 4, filter memory gated by write pointer");
    applyStimulus(0, 1, 4, 2, 9, 10, 1, 1'b0, 8, 1'b1);
    finishPass("twoFilt", 1'b0, 0, 1'b0);

    $display("[TB] backpressure and start while busy");
    readyRandom = 1'b1;
    applyStimulus(0, 1, 3, 1, 9, 10, 1, 1'b1, 0, 1'b1);
    finishPass("backpressure", 1'b0, 0, 1'b1);

    $display("[TB] write pointer trails the reads");
    readyRandom = 1'b0;
    applyStimulus(0, 1, 3, 1, 9, 1, 1, 1'b1, 0, 1'b1);
    finishPass("throttle", 1'b1, 10, 1'b0);

    $display("[TB] end pointer not yet final");
    applyStimulus(0, 1, 3, 1, 9, 10, 1, 1'b1, 0, 1'b0);
    waitQueue(1, 1'b0, 0, 1'b0, done);
    checkOutput("stallReached", int'(done), 1);
    repeat (10) @(posedge clk);
    #1;
    checkOutput("stallBusy", int'(busy), 1);
    checkOutput("stallRdValid", int'(rd_valid), 0);
    if_end_valid = 1'b1;
    finishPass("stall", 1'b0, 0, 1'b0);

`ifdef CONV_RADDR_DILATION_EN
    $display("[TB] dilation 2, len 3");
    applyStimulus(0, 1, 3, 1, 9, 10, 2, 1'b1, 0, 1'b1);
    finishPass("dilation", 1'b0, 0, 1'b0);
`endif

    $display("[TB] randomized passes");
    readyRandom = 1'b1;
    for (int p = 0; p < 8; p++) begin
      stride = $urandom_range(1, 3);
      len    = $urandom_range(1, 5);
      nf     = $urandom_range(1, 4);
      sp     = $urandom_range(0, DEPTH - 1);
`ifdef CONV_RADDR_DILATION_EN
      dil    = $urandom_range(0, 2);
`else
      dil    = 1;
`endif
      lo = (len - 1) * ((dil == 0) ? 1 : dil);
      e  = $urandom_range(lo, DEPTH - 1 - stride);
      applyStimulus(sp, stride, len, nf, (sp + e) % DEPTH, (sp + e + 1) % DEPTH, dil,
                    p[0], nf * len, 1'b1);
      finishPass("random", 1'b0, 0, 1'b1);
    end

    $display("[TB] reset in the middle of a pass");
    readyRandom = 1'b0;
    applyStimulus(0, 1, 3, 1, 9, 10, 1, 1'b1, 0, 1'b1);
    repeat (6) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    expQ.delete();
    checkOutput("abortBusy", int'(busy), 0);
    checkOutput("abortRdValid", int'(rd_valid), 0);
    checkOutput("abortWinDone", int'(win_done), 0);
    checkOutput("abortFullDone", int'(full_done), 0);
    repeat (20) @(posedge clk);
    #1;
    checkOutput("abortStaysIdle", int'(busy), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule

// File: doc/conv_raddr_gen.md
CONV_RADDR_GEN -- requirements
Module: conv_raddr_gen

Interface
REQ-001 SHALL have parameter IF_ADDR_LEN, default 5, IF scratchpad address width.
REQ-002 SHALL have parameter FILT_ADDR_LEN, default 6, filter scratchpad address width.
REQ-003 SHALL have parameter IF_DEPTH, default 24, IF scratchpad entries, any value 2..2^IF_ADDR_LEN, not required power of two.
REQ-004 SHALL have parameter NUM_FILT_MAX, default 4, maximum filters per pass.
REQ-005 Ports: clk  in  1  the single clock; rst  in  1  reset, synchronous and active-high.
REQ-006 Ports: start  in  1  begin pass; psum_done  in  1  window's partial sum retired.
REQ-007 Ports: cfg_stride  in  IF_ADDR_LEN  window step; cfg_filt_len  in  FILT_ADDR_LEN  taps per filter (>=1).
REQ-008 Ports: cfg_num_filt  in  clog2(NUM_FILT_MAX)+1  filters this pass (1..NUM_FILT_MAX); cfg_dilation  in  IF_ADDR_LEN  tap spacing (DILATION_EN only).
REQ-009 Ports: if_start_pos, if_end_pos, if_waddr  in  IF_ADDR_LEN  circular IF pointers; if_end_valid  in  1  if_end_pos final.
REQ-010 Ports: filt_waddr  in  FILT_ADDR_LEN  filter write pointer; filt_ready  in  1  filter memory fully loaded.
REQ-011 Ports: rd_ready  in  1  consumer accepts address; rd_valid  out  1  address pair valid.
REQ-012 Ports: if_raddr  out  IF_ADDR_LEN; filt_raddr  out  FILT_ADDR_LEN; tap_last  out  1  final tap of window.
REQ-013 Ports: win_done  out  1  pulse, window complete; full_done  out  1  pulse, pass complete; busy  out  1  not IDLE.

Function
REQ-014 FSM states SHALL be IDLE, FILT_INIT, WIN_INIT, READ, WAIT_PSUM; IDLE->FILT_INIT on start.
REQ-015 FILT_INIT: if filt_idx==cfg_num_filt -> pulse full_done, go IDLE; else clear win_idx, go WIN_INIT.
REQ-016 WIN_INIT: if window overflow (REQ-022) -> filt_idx++, go FILT_INIT; else clear tap, go READ.
REQ-017 if_raddr SHALL equal (if_start_pos + win_idx*cfg_stride + tap*D) mod IF_DEPTH, D=cfg_dilation with DILATION_EN else 1; intermediates at 2*IF_ADDR_LEN bits, no truncation before mod.
REQ-018 filt_raddr SHALL equal filt_idx*cfg_filt_len + tap, truncated to FILT_ADDR_LEN.
REQ-019 Circular distance dist(a)=(a - if_start_pos + IF_DEPTH) mod IF_DEPTH; read_safe = dist(if_raddr)<dist(if_waddr) AND (filt_raddr<filt_waddr OR filt_ready).
REQ-020 rd_valid SHALL be high only in READ with read_safe; tap increments on rd_valid&rd_ready; tap_last = (tap==cfg_filt_len-1).
REQ-021 Handshake on last tap SHALL move to WAIT_PSUM; psum_done there SHALL pulse win_done, win_idx++, go WIN_INIT; psum_done outside WAIT_PSUM ignored.
REQ-022 Overflow: dist(window last tap address) > dist(if_end_pos) AND if_end_valid; if if_end_valid low, WIN_INIT SHALL stall until either no overflow or valid.
REQ-023 Outputs SHALL hold stable while rd_valid high and rd_ready low.
REQ-024 start while busy SHALL be ignored.
REQ-025 Address to rd_valid latency SHALL be zero (combinational from registered state); one tap per cycle sustained.

Reset
REQ-026 rst SHALL force IDLE, filt_idx, win_idx, tap to 0; rd_valid, win_done, full_done, busy low; mid-pass rst aborts with no pulses.

Configuration
REQ-027 Macro CONV_RADDR_DILATION_EN defined: cfg_dilation port present, value 0 treated as 1.
REQ-028 Macro undefined: cfg_dilation port absent, D fixed at 1, no multiplier for tap term.

Structure
REQ-029 Shared package conv_raddr_pkg SHALL hold state enum type and circular-distance function.
REQ-030 Sub-module conv_circ_dist SHALL compute REQ-019 distance; instanced per compared pointer.

Verification
REQ-031 IF_DEPTH=24, start=0, len=3, stride=1, end=9 valid, 1 filter, rd_ready=1 -> windows 0..7, if_raddr 0,1,2,1,2,3..., 8 win_done, full_done.
REQ-032 start=20, len=3, stride=2 -> first windows read 20,21,22 then 22,23,0 (wrap at 24).
REQ-033 if_waddr=start+1 then advancing one per 5 cycles -> rd_valid low until data written; no address beyond write pointer issued.
REQ-034 cfg_num_filt=2, len=4 -> second-filter filt_raddr 4..7; full_done one cycle after last window of filter 1.
REQ-035 rd_ready toggled pseudo-randomly -> addresses held under backpressure, sequence identical to REQ-031.
REQ-036 DILATION_EN, dilation=2, len=3 -> window 0 reads 0,2,4; rst asserted mid-window -> IDLE next cycle, no pulses.
